// File: rtl/phmm_job_sequencer.sv
// Pair-HMM job sequencer: latches job config, buffers bases/priors, serves systolic_array
// index requests and returns final value, RUN cycle count and error status.
module phmm_job_sequencer #(
   parameter int unsigned       MAX_LEN   = 64,
   parameter int unsigned       IDX_W     = $clog2(MAX_LEN),
   parameter int unsigned       BASE_W    = 3,
   parameter logic [BASE_W-1:0] BASE_DASH = 3'd4,
   parameter int unsigned       WDOG      = 32'd1048576
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [IDX_W:0]    cfg_x_len,
   input  logic [IDX_W:0]    cfg_y_len,
   input  logic [447:0]      cfg_tp,
   input  logic              ld_valid,
   input  logic              ld_sel,
   input  logic [IDX_W-1:0]  ld_addr,
   input  logic [BASE_W-1:0] ld_base,
   input  logic [63:0]       ld_match,
   input  logic [63:0]       ld_neq,
   input  logic              start,
   output logic              busy,
   output logic              sa_reset,
   output logic [IDX_W-1:0]  sa_x_len,
   output logic [IDX_W-1:0]  sa_y_len,
   output logic [447:0]      sa_tp,
   input  logic [IDX_W-1:0]  sa_idx_x,
   input  logic              sa_x_vld,
   input  logic [IDX_W-1:0]  sa_idx_y,
   input  logic              sa_y_vld,
   output logic [BASE_W-1:0] sa_ref_base,
   output logic              sa_ref_vld,
   output logic [BASE_W-1:0] sa_exp_base,
   output logic              sa_exp_vld,
   output logic [63:0]       sa_match,
   output logic [63:0]       sa_neq,
   input  logic              sa_complete,
   input  logic [63:0]       sa_final_val,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [63:0]       res_val,
   output logic [31:0]       res_cycles,
   output logic              res_err
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CLEAR = 2'd1, ST_RUN = 2'd2, ST_DONE = 2'd3} state_t;

   localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);
   localparam logic [31:0]    WDOG_L  = 32'(WDOG);

   state_t              state_q, state_d;
   logic                cfg_seen_q, cfg_seen_d;
   logic [IDX_W:0]      x_len_q, x_len_d, y_len_q, y_len_d;
   logic [447:0]        tp_q, tp_d;
   logic                sa_reset_q, sa_reset_d, clr_cnt_q, clr_cnt_d;
   logic                busy_q, busy_d, cfg_ready_q, cfg_ready_d;
   logic [31:0]         cyc_q, cyc_d, cyc_inc_s;
   logic                err_q, err_d;
   logic [BASE_W-1:0]   ref_base_q, ref_base_d, exp_base_q, exp_base_d;
   logic                ref_vld_q, ref_vld_d, exp_vld_q, exp_vld_d;
   logic [63:0]         match_q, match_d, neq_q, neq_d;
   logic                res_valid_q, res_valid_d, res_err_q, res_err_d;
   logic [63:0]         res_val_q, res_val_d;
   logic [31:0]         res_cycles_q, res_cycles_d;
   logic                x_ok_s, y_ok_s, len_bad_s;

   logic [BASE_W-1:0]   ref_mem [MAX_LEN];
   logic [BASE_W-1:0]   rd_mem  [MAX_LEN];
   logic [63:0]         mt_mem  [MAX_LEN];
   logic [63:0]         nq_mem  [MAX_LEN];

   assign x_ok_s    = ({1'b0, sa_idx_x} < x_len_q);
   assign y_ok_s    = ({1'b0, sa_idx_y} < y_len_q);
   assign len_bad_s = (x_len_q == '0) || (x_len_q > LEN_MAX) || (y_len_q == '0) || (y_len_q > LEN_MAX);
   assign cyc_inc_s = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d      = state_q;
      cfg_seen_d   = cfg_seen_q;
      x_len_d      = x_len_q;
      y_len_d      = y_len_q;
      tp_d         = tp_q;
      sa_reset_d   = sa_reset_q;
      clr_cnt_d    = clr_cnt_q;
      cyc_d        = cyc_q;
      err_d        = err_q;
      ref_base_d   = ref_base_q;
      ref_vld_d    = ref_vld_q;
      exp_base_d   = exp_base_q;
      exp_vld_d    = exp_vld_q;
      match_d      = match_q;
      neq_d        = neq_q;
      res_valid_d  = res_valid_q;
      res_val_d    = res_val_q;
      res_cycles_d = res_cycles_q;
      res_err_d    = res_err_q;
      case (state_q)
         ST_IDLE: begin
            sa_reset_d = 1'b0;
            if (cfg_valid) begin
               x_len_d    = cfg_x_len;
               y_len_d    = cfg_y_len;
               tp_d       = cfg_tp;
               cfg_seen_d = 1'b1;
            end else begin
               cfg_seen_d = cfg_seen_q;
            end
            if (start && cfg_seen_q) begin
               state_d    = ST_CLEAR;
               sa_reset_d = 1'b1;
               clr_cnt_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            sa_reset_d = 1'b1;
            cyc_d      = 32'd0;
            err_d      = 1'b0;
            ref_base_d = '0;
            ref_vld_d  = 1'b0;
            exp_base_d = '0;
            exp_vld_d  = 1'b0;
            match_d    = 64'd0;
            neq_d      = 64'd0;
            if (clr_cnt_q == 1'b0) begin
               clr_cnt_d = 1'b1;
            end else if (len_bad_s) begin
               sa_reset_d   = 1'b0;
               state_d      = ST_DONE;
               res_valid_d  = 1'b1;
               res_err_d    = 1'b1;
               res_val_d    = 64'd0;
               res_cycles_d = 32'd0;
            end else begin
               sa_reset_d = 1'b0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            cyc_d = cyc_inc_s;
            if (sa_x_vld) begin
               ref_base_d = x_ok_s ? ref_mem[sa_idx_x] : BASE_DASH;
               ref_vld_d  = 1'b1;
               err_d      = err_d | ~x_ok_s;
            end else begin
               ref_base_d = ref_base_q;
            end
            // Priors travel with the read base; an out-of-range index yields zero priors
            if (sa_y_vld) begin
               exp_base_d = y_ok_s ? rd_mem[sa_idx_y] : BASE_DASH;
               match_d    = y_ok_s ? mt_mem[sa_idx_y] : 64'd0;
               neq_d      = y_ok_s ? nq_mem[sa_idx_y] : 64'd0;
               exp_vld_d  = 1'b1;
               err_d      = err_d | ~y_ok_s;
            end else begin
               exp_base_d = exp_base_q;
            end
            if (sa_complete) begin
               state_d      = ST_DONE;
               res_valid_d  = 1'b1;
               res_err_d    = err_d;
               res_val_d    = err_d ? 64'd0 : sa_final_val;
               res_cycles_d = cyc_inc_s;
            end else if (cyc_inc_s >= WDOG_L) begin
               state_d      = ST_DONE;
               err_d        = 1'b1;
               res_valid_d  = 1'b1;
               res_err_d    = 1'b1;
               res_val_d    = 64'd0;
               res_cycles_d = cyc_inc_s;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d     = ST_IDLE;
               res_valid_d = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d      = (state_d != ST_IDLE);
      cfg_ready_d = (state_d == ST_IDLE);
   end

   // Control and output registers; reset aborts any job in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cfg_seen_q   <= 1'b0;
         x_len_q      <= '0;
         y_len_q      <= '0;
         tp_q         <= 448'd0;
         sa_reset_q   <= 1'b1;
         clr_cnt_q    <= 1'b0;
         busy_q       <= 1'b0;
         cfg_ready_q  <= 1'b1;
         cyc_q        <= 32'd0;
         err_q        <= 1'b0;
         ref_base_q   <= '0;
         ref_vld_q    <= 1'b0;
         exp_base_q   <= '0;
         exp_vld_q    <= 1'b0;
         match_q      <= 64'd0;
         neq_q        <= 64'd0;
         res_valid_q  <= 1'b0;
         res_val_q    <= 64'd0;
         res_cycles_q <= 32'd0;
         res_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_seen_q   <= cfg_seen_d;
         x_len_q      <= x_len_d;
         y_len_q      <= y_len_d;
         tp_q         <= tp_d;
         sa_reset_q   <= sa_reset_d;
         clr_cnt_q    <= clr_cnt_d;
         busy_q       <= busy_d;
         cfg_ready_q  <= cfg_ready_d;
         cyc_q        <= cyc_d;
         err_q        <= err_d;
         ref_base_q   <= ref_base_d;
         ref_vld_q    <= ref_vld_d;
         exp_base_q   <= exp_base_d;
         exp_vld_q    <= exp_vld_d;
         match_q      <= match_d;
         neq_q        <= neq_d;
         res_valid_q  <= res_valid_d;
         res_val_q    <= res_val_d;
         res_cycles_q <= res_cycles_d;
         res_err_q    <= res_err_d;
      end
   end

   // Base/prior buffers keep their contents across reset
   always_ff @(posedge clk) begin
      if (ld_valid && (state_q == ST_IDLE)) begin
         if (ld_sel) begin
            rd_mem[ld_addr] <= ld_base;
            mt_mem[ld_addr] <= ld_match;
            nq_mem[ld_addr] <= ld_neq;
         end else begin
            ref_mem[ld_addr] <= ld_base;
         end
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign busy        = busy_q;
   assign sa_reset    = sa_reset_q;
   assign sa_x_len    = x_len_q[IDX_W-1:0];
   assign sa_y_len    = y_len_q[IDX_W-1:0];
   assign sa_tp       = tp_q;
   assign sa_ref_base = ref_base_q;
   assign sa_ref_vld  = ref_vld_q;
   assign sa_exp_base = exp_base_q;
   assign sa_exp_vld  = exp_vld_q;
   assign sa_match    = match_q;
   assign sa_neq      = neq_q;
   assign res_valid   = res_valid_q;
   assign res_val     = res_val_q;
   assign res_cycles  = res_cycles_q;
   assign res_err     = res_err_q;

endmodule

// File: tb/tb_phmm_job_sequencer.sv
// Randomized self-checking bench for phmm_job_sequencer against a job-level reference model.
module tb_phmm_job_sequencer;
   localparam int WDOG = 100;

   logic clk, reset;
   logic cfg_valid, cfg_ready;
   logic [6:0] cfg_x_len, cfg_y_len;
   logic [447:0] cfg_tp;
   logic ld_valid, ld_sel;
   logic [5:0] ld_addr;
   logic [2:0] ld_base;
   logic [63:0] ld_match, ld_neq;
   logic start, busy, sa_reset;
   logic [5:0] sa_x_len, sa_y_len;
   logic [447:0] sa_tp;
   logic [5:0] sa_idx_x, sa_idx_y;
   logic sa_x_vld, sa_y_vld;
   logic [2:0] sa_ref_base, sa_exp_base;
   logic sa_ref_vld, sa_exp_vld;
   logic [63:0] sa_match, sa_neq;
   logic sa_complete;
   logic [63:0] sa_final_val;
   logic res_valid, res_ready, res_err;
   logic [63:0] res_val;
   logic [31:0] res_cycles;

   phmm_job_sequencer #(.MAX_LEN(64), .BASE_W(3), .BASE_DASH(3'd4), .WDOG(WDOG)) dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_x_len(cfg_x_len), .cfg_y_len(cfg_y_len), .cfg_tp(cfg_tp),
      .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_base(ld_base),
      .ld_match(ld_match), .ld_neq(ld_neq), .start(start), .busy(busy), .sa_reset(sa_reset),
      .sa_x_len(sa_x_len), .sa_y_len(sa_y_len), .sa_tp(sa_tp),
      .sa_idx_x(sa_idx_x), .sa_x_vld(sa_x_vld), .sa_idx_y(sa_idx_y), .sa_y_vld(sa_y_vld),
      .sa_ref_base(sa_ref_base), .sa_ref_vld(sa_ref_vld), .sa_exp_base(sa_exp_base),
      .sa_exp_vld(sa_exp_vld), .sa_match(sa_match), .sa_neq(sa_neq),
      .sa_complete(sa_complete), .sa_final_val(sa_final_val),
      .res_valid(res_valid), .res_ready(res_ready), .res_val(res_val),
      .res_cycles(res_cycles), .res_err(res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference contents of the buffers as the host loaded them
   logic [2:0]  ref_m [64];
   logic [2:0]  rd_m  [64];
   logic [63:0] mt_m  [64];
   logic [63:0] nq_m  [64];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic load_bufs(input bit tcga);
      for (int i = 0; i < 64; i++) begin
         for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_sel   = s[0];
            ld_addr  = i[5:0];
            ld_base  = (tcga && i < 4) ? i[2:0] : 3'($urandom_range(0, 4));
            ld_match = {$urandom, $urandom};
            ld_neq   = {$urandom, $urandom};
            if (s == 0) ref_m[i] = ld_base;
            else begin
               rd_m[i] = ld_base;
               mt_m[i] = ld_match;
               nq_m[i] = ld_neq;
            end
         end
      end
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic job(input int xl, input int yl, input int done_at, input bit oob_ok,
                      input bit tcga, input int abort_at, input bit load, input int hold_n);
      logic [447:0] tp;
      logic [63:0]  fval, e_mt, e_nq, e_val;
      logic [2:0]   e_ref, e_exp;
      logic         e_rv, e_ev, e_err, fin;
      logic [7:0]   lx, ly;
      int           ix, iy, hold, n, e_cyc;
      bit           bad;
      if (load) load_bufs(tcga);
      for (int k = 0; k < 14; k++) tp[k*32 +: 32] = $urandom;
      fval = {$urandom, $urandom};
      lx = 8'(xl);
      ly = 8'(yl);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_x_len = 7'($urandom);
      cfg_y_len = 7'($urandom);
      cfg_tp    = ~tp;
      @(negedge clk);
      chk("cfg_ready_idle", {63'd0, cfg_ready}, 64'd1);
      cfg_x_len = lx[6:0];
      cfg_y_len = ly[6:0];
      cfg_tp    = tp;
      @(negedge clk);
      cfg_valid = 1'b0;
      bad = (xl == 0) || (xl > 64) || (yl == 0) || (yl > 64);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("clear1_busy", {63'd0, busy}, 64'd1);
      chk("clear1_sa_reset", {63'd0, sa_reset}, 64'd1);
      chk("clear1_cfg_ready", {63'd0, cfg_ready}, 64'd0);
      chk("sa_x_len", {58'd0, sa_x_len}, {58'd0, lx[5:0]});
      chk("sa_y_len", {58'd0, sa_y_len}, {58'd0, ly[5:0]});
      chk("sa_tp", {63'd0, (sa_tp === tp)}, 64'd1);
      @(negedge clk);
      chk("clear2_sa_reset", {63'd0, sa_reset}, 64'd1);
      chk("clear2_feeds", {62'd0, sa_ref_vld, sa_exp_vld}, 64'd0);
      @(negedge clk);
      chk("post_clear_sa_reset", {63'd0, sa_reset}, 64'd0);
      if (bad) begin
         e_val = 64'd0; e_err = 1'b1; e_cyc = 0;
      end else begin
         chk("run_res_valid", {63'd0, res_valid}, 64'd0);
         e_ref = 3'd0; e_exp = 3'd0; e_rv = 1'b0; e_ev = 1'b0;
         e_mt = 64'd0; e_nq = 64'd0; e_err = 1'b0;
         e_val = 64'd0; e_cyc = 0;
         for (n = 1; n <= WDOG; n++) begin
            fin = (n == done_at) || (n == WDOG);
            if (n == abort_at) begin
               reset = 1'b0;
               #1;
               chk("abort_busy", {63'd0, busy}, 64'd0);
               chk("abort_sa_reset", {63'd0, sa_reset}, 64'd1);
               chk("abort_res_valid", {63'd0, res_valid}, 64'd0);
               chk("abort_feeds", {62'd0, sa_ref_vld, sa_exp_vld}, 64'd0);
               chk("abort_cfg_cleared", {58'd0, sa_x_len}, 64'd0);
               @(negedge clk);
               reset = 1'b1;
               @(negedge clk);
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
               @(negedge clk);
               chk("start_no_cfg_after_abort", {63'd0, busy}, 64'd0);
               return;
            end
            sa_x_vld = 1'b0;
            sa_y_vld = 1'b0;
            if (!fin) begin
               sa_x_vld = 1'($urandom_range(0, 1));
               sa_y_vld = 1'($urandom_range(0, 1));
               ix = oob_ok ? $urandom_range(0, 63) : $urandom_range(0, xl - 1);
               iy = oob_ok ? $urandom_range(0, 63) : $urandom_range(0, yl - 1);
               if (tcga && n == 1) begin sa_x_vld = 1'b1; sa_y_vld = 1'b1; ix = 2; iy = 1; end
               if (tcga && oob_ok && n == 2) begin sa_x_vld = 1'b1; sa_y_vld = 1'b0; ix = 5; end
               sa_idx_x = ix[5:0];
               sa_idx_y = iy[5:0];
               if (sa_x_vld) begin
                  e_rv = 1'b1;
                  if (ix < xl) e_ref = ref_m[ix];
                  else begin e_ref = 3'd4; e_err = 1'b1; end
               end
               if (sa_y_vld) begin
                  e_ev = 1'b1;
                  if (iy < yl) begin e_exp = rd_m[iy]; e_mt = mt_m[iy]; e_nq = nq_m[iy]; end
                  else begin e_exp = 3'd4; e_mt = 64'd0; e_nq = 64'd0; e_err = 1'b1; end
               end
            end
            sa_complete  = (n == done_at);
            sa_final_val = (n == done_at) ? fval : {$urandom, $urandom};
            ld_valid = 1'($urandom_range(0, 1));
            ld_sel   = 1'($urandom_range(0, 1));
            ld_addr  = 6'($urandom);
            ld_base  = 3'($urandom);
            @(negedge clk);
            sa_complete = 1'b0;
            sa_x_vld = 1'b0;
            sa_y_vld = 1'b0;
            ld_valid = 1'b0;
            chk("ref_feed", {60'd0, e_rv, sa_ref_base}, {60'd0, e_rv, e_ref});
            chk("ref_vld", {63'd0, sa_ref_vld}, {63'd0, e_rv});
            chk("exp_feed", {60'd0, sa_exp_vld, sa_exp_base}, {60'd0, e_ev, e_exp});
            chk("match_feed", sa_match, e_mt);
            chk("neq_feed", sa_neq, e_nq);
            if (fin) begin
               e_cyc = n;
               if (n == done_at) e_val = e_err ? 64'd0 : fval;
               else begin e_err = 1'b1; e_val = 64'd0; end
               break;
            end
            chk("run_not_done", {62'd0, busy, res_valid}, 64'd2);
         end
      end
      chk("done_res_valid", {63'd0, res_valid}, 64'd1);
      chk("done_res_val", res_val, e_val);
      chk("done_res_err", {63'd0, res_err}, {63'd0, e_err});
      chk("done_res_cycles", {32'd0, res_cycles}, 64'(e_cyc));
      hold = (hold_n >= 0) ? hold_n : $urandom_range(0, 10);
      for (int h = 0; h < hold; h++) begin
         start = 1'($urandom_range(0, 1));
         @(negedge clk);
         start = 1'b0;
         chk("hold_valid_busy", {62'd0, res_valid, busy}, 64'd3);
         chk("hold_res_val", res_val, e_val);
         chk("hold_res_cycles", {32'd0, res_cycles}, 64'(e_cyc));
         chk("hold_res_err", {63'd0, res_err}, {63'd0, e_err});
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("ack_res_valid", {63'd0, res_valid}, 64'd0);
      chk("ack_idle", {62'd0, busy, cfg_ready}, 64'd1);
   endtask

   initial begin
      reset = 1'b0; cfg_valid = 1'b0; cfg_x_len = 7'd0; cfg_y_len = 7'd0; cfg_tp = 448'd0;
      ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 6'd0; ld_base = 3'd0;
      ld_match = 64'd0; ld_neq = 64'd0; start = 1'b0;
      sa_idx_x = 6'd0; sa_x_vld = 1'b0; sa_idx_y = 6'd0; sa_y_vld = 1'b0;
      sa_complete = 1'b0; sa_final_val = 64'd0; res_ready = 1'b0;
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_sa_reset", {63'd0, sa_reset}, 64'd1);
      chk("rst_res", {res_val[31:0] | res_cycles, 29'd0, res_valid, res_err, 1'b0}, 64'd0);
      chk("rst_feeds", {56'd0, sa_ref_vld, sa_exp_vld, sa_x_len}, 64'd0);
      chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_sa_reset_low", {63'd0, sa_reset}, 64'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("start_without_cfg", {63'd0, busy}, 64'd0);

      job(4, 4, 30, 1'b0, 1'b1, 0, 1'b1, 10);
      job(0, 4, 0, 1'b0, 1'b0, 0, 1'b0, -1);
      job(4, 4, 20, 1'b1, 1'b1, 0, 1'b1, -1);
      job(8, 6, 0, 1'b0, 1'b0, 0, 1'b1, 3);
      job(10, 10, 40, 1'b0, 1'b0, 15, 1'b1, -1);
      job(12, 9, 25, 1'b0, 1'b0, 0, 1'b0, -1);
      job(64, 64, 33, 1'b1, 1'b0, 0, 1'b0, -1);
      job(100, 7, 10, 1'b0, 1'b0, 0, 1'b0, -1);
      for (int j = 0; j < 8; j++) begin
         int xl, yl, da;
         xl = ($urandom_range(0, 7) == 0) ? $urandom_range(65, 127) : $urandom_range(1, 64);
         yl = $urandom_range(1, 64);
         da = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60);
         job(xl, yl, da, 1'($urandom_range(0, 1)), 1'b0, 0, 1'($urandom_range(0, 1)), -1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
